// File: rtl/pr_hssi_lpbk_lane_model.sv
// Parametrised per-lane HSSI loopback model: AFU Tx is looped back to AFU Rx
// through a fixed-latency pipeline, with block-lock bring-up emulation,
// lane enable, single-bit error injection and drop/injection statistics.
module pr_hssi_lpbk_lane_model #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned TX_CTRL_W   = 18,
    parameter int unsigned RX_CTRL_W   = 20,
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned LOCK_CYCLES = 64,
    localparam int unsigned ERR_LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            pClk,
    input  logic                            rst_n,
    input  logic [NUM_LANES-1:0]            cfg_lane_en,
    input  logic [NUM_LANES-1:0]            a2f_tx_valid,
    input  logic [NUM_LANES*DATA_W-1:0]     a2f_tx_parallel_data,
    input  logic [NUM_LANES*TX_CTRL_W-1:0]  a2f_tx_control,
    input  logic                            cfg_inject_err,
    input  logic [ERR_LANE_W-1:0]           cfg_err_lane,
    output logic [NUM_LANES-1:0]            f2a_rx_valid,
    output logic [NUM_LANES*DATA_W-1:0]     f2a_rx_parallel_data,
    output logic [NUM_LANES*RX_CTRL_W-1:0]  f2a_rx_control,
    output logic [NUM_LANES-1:0]            f2a_rx_blk_lock,
    output logic                            err_armed,
    output logic [15:0]                     inj_cnt,
    output logic [15:0]                     drop_cnt
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int unsigned POP_W  = $clog2(NUM_LANES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        DOWN    = 2'd0,
        LOCKING = 2'd1,
        UP      = 2'd2
    } laneState_t;

    logic [NUM_LANES-1:0]  laneUp;     // lane is UP this cycle
    logic [NUM_LANES-1:0]  laneHold;   // lane is still UP after this edge
    logic [NUM_LANES-1:0]  txAccept;
    logic [NUM_LANES-1:0]  txDrop;
    logic [NUM_LANES-1:0]  injHit;
    logic                  errArmed;
    logic [ERR_LANE_W-1:0] errLane;
    logic                  errLaneOk;
    logic [POP_W-1:0]      dropPop;
    logic [SUM_W-1:0]      dropSum;

    for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
        laneState_t           state;
        laneState_t           stateNext;
        logic [LOCK_W-1:0]    lockCnt;
        logic [LOCK_W-1:0]    lockCntNext;
        logic [LOCK_W-1:0]    lockCntInc;
        logic [DATA_W-1:0]    txData;
        logic                 pipeValid [LATENCY];
        logic [TX_CTRL_W-1:0] pipeCtrl  [LATENCY];
        logic [DATA_W-1:0]    pipeData  [LATENCY];

        assign lockCntInc = lockCnt + LOCK_W'(1);

        // Lane bring-up state register
        always_ff @(posedge pClk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= DOWN;
                lockCnt <= '0;
            end else begin
                state   <= stateNext;
                lockCnt <= lockCntNext;
            end
        end

        // Bring-up sequencing: lock lands LOCK_CYCLES cycles after the first enabled cycle
        always_comb begin
            stateNext   = state;
            lockCntNext = lockCnt;
            if (!cfg_lane_en[i]) begin
                stateNext   = DOWN;
                lockCntNext = '0;
            end else begin
                unique case (state)
                    DOWN: begin
                        lockCntNext = '0;
                        stateNext   = (LOCK_CYCLES == 1) ? UP : LOCKING;
                    end
                    LOCKING: begin
                        lockCntNext = lockCntInc;
                        if (lockCntInc == LOCK_LAST) begin
                            stateNext = UP;
                        end
                    end
                    UP:      stateNext = UP;
                    default: stateNext = DOWN;
                endcase
            end
        end

        assign laneUp[i]   = (state == UP);
        assign laneHold[i] = (stateNext == UP);
        assign txAccept[i] = a2f_tx_valid[i] & laneUp[i];
        assign txDrop[i]   = a2f_tx_valid[i] & ~laneUp[i];
        assign injHit[i]   = errArmed & txAccept[i] & (errLane == ERR_LANE_W'(i));
        assign txData      = a2f_tx_parallel_data[i*DATA_W +: DATA_W] ^ DATA_W'(injHit[i]);

        // Loopback pipeline; a lane leaving UP flushes its in-flight beats
        always_ff @(posedge pClk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < int'(LATENCY); s++) begin
                    pipeValid[s] <= 1'b0;
                    pipeCtrl[s]  <= '0;
                    pipeData[s]  <= '0;
                end
            end else begin
                pipeValid[0] <= txAccept[i] & laneHold[i];
                pipeCtrl[0]  <= a2f_tx_control[i*TX_CTRL_W +: TX_CTRL_W];
                pipeData[0]  <= txData;
                for (int s = 1; s < int'(LATENCY); s++) begin
                    pipeValid[s] <= pipeValid[s-1] & laneHold[i];
                    pipeCtrl[s]  <= pipeCtrl[s-1];
                    pipeData[s]  <= pipeData[s-1];
                end
            end
        end

        assign f2a_rx_valid[i]                            = pipeValid[LATENCY-1];
        assign f2a_rx_parallel_data[i*DATA_W +: DATA_W]   = pipeData[LATENCY-1];
        assign f2a_rx_control[i*RX_CTRL_W +: RX_CTRL_W]   = RX_CTRL_W'(pipeCtrl[LATENCY-1]);
        assign f2a_rx_blk_lock[i]                         = laneUp[i];
    end

    // Lane index range check only exists when the select field can exceed the lane count
    if ((1 << ERR_LANE_W) > NUM_LANES) begin : g_lane_chk
        assign errLaneOk = (32'(cfg_err_lane) < NUM_LANES);
    end else begin : g_lane_all
        assign errLaneOk = 1'b1;
    end

    // Error injection arm/apply; arming is ignored while already armed
    always_ff @(posedge pClk or negedge rst_n) begin
        if (!rst_n) begin
            errArmed <= 1'b0;
            errLane  <= '0;
            inj_cnt  <= '0;
        end else if (errArmed) begin
            if (|injHit) begin
                errArmed <= 1'b0;
                if (inj_cnt != '1) begin
                    inj_cnt <= inj_cnt + CNT_W'(1);
                end
            end
        end else if (cfg_inject_err && errLaneOk) begin
            errArmed <= 1'b1;
            errLane  <= cfg_err_lane;
        end
    end

    assign err_armed = errArmed;

    // Number of lanes dropping a beat this cycle
    always_comb begin
        dropPop = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            dropPop = dropPop + POP_W'(txDrop[i]);
        end
    end

    assign dropSum = SUM_W'(drop_cnt) + SUM_W'(dropPop);

    // Saturating drop counter
    always_ff @(posedge pClk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pr_hssi_lpbk_lane_model.sv
// Scoreboard bench for the loopback lane model: stimulus pushes expected Rx
// beats (with due cycle), a monitor pops and compares whenever Rx valid rises.
`timescale 1ns/1ps
module tb_pr_hssi_lpbk_lane_model;

    localparam int NL  = 4;
    localparam int DW  = 128;
    localparam int TCW = 18;
    localparam int RCW = 20;
    localparam int LAT = 4;
    localparam int LCK = 64;

    logic              pClk = 1'b0;
    logic              rst_n;
    logic [NL-1:0]     cfg_lane_en;
    logic [NL-1:0]     a2f_tx_valid;
    logic [NL*DW-1:0]  a2f_tx_parallel_data;
    logic [NL*TCW-1:0] a2f_tx_control;
    logic              cfg_inject_err;
    logic [1:0]        cfg_err_lane;
    logic [NL-1:0]     f2a_rx_valid;
    logic [NL*DW-1:0]  f2a_rx_parallel_data;
    logic [NL*RCW-1:0] f2a_rx_control;
    logic [NL-1:0]     f2a_rx_blk_lock;
    logic              err_armed;
    logic [15:0]       inj_cnt;
    logic [15:0]       drop_cnt;

    typedef struct packed {
        logic [31:0]    lane;
        logic [DW-1:0]  data;
        logic [RCW-1:0] ctrl;
        logic [31:0]    due;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;
    int   cycCnt = 0;

    pr_hssi_lpbk_lane_model #(
        .NUM_LANES(NL), .DATA_W(DW), .TX_CTRL_W(TCW), .RX_CTRL_W(RCW),
        .LATENCY(LAT), .LOCK_CYCLES(LCK)
    ) dut (
        .pClk                 (pClk),
        .rst_n                (rst_n),
        .cfg_lane_en          (cfg_lane_en),
        .a2f_tx_valid         (a2f_tx_valid),
        .a2f_tx_parallel_data (a2f_tx_parallel_data),
        .a2f_tx_control       (a2f_tx_control),
        .cfg_inject_err       (cfg_inject_err),
        .cfg_err_lane         (cfg_err_lane),
        .f2a_rx_valid         (f2a_rx_valid),
        .f2a_rx_parallel_data (f2a_rx_parallel_data),
        .f2a_rx_control       (f2a_rx_control),
        .f2a_rx_blk_lock      (f2a_rx_blk_lock),
        .err_armed            (err_armed),
        .inj_cnt              (inj_cnt),
        .drop_cnt             (drop_cnt)
    );

    always #5 pClk = ~pClk;

    always @(posedge pClk) cycCnt <= cycCnt + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge pClk);
    endtask

    task automatic clearTx();
        a2f_tx_valid = '0;
    endtask

    // Present a beat on one lane this cycle; optionally record the Rx beat it must produce
    task automatic setBeat(input int lane, input logic [DW-1:0] d, input logic [TCW-1:0] c,
                           input logic [DW-1:0] expD, input logic [RCW-1:0] expC, input bit push);
        exp_t e;
        a2f_tx_valid[lane] = 1'b1;
        a2f_tx_parallel_data[lane*DW +: DW] = d;
        a2f_tx_control[lane*TCW +: TCW] = c;
        if (push) begin
            e.lane = 32'(lane);
            e.data = expD;
            e.ctrl = expC;
            e.due  = 32'(cycCnt + LAT);
            expQ.push_back(e);
        end
    endtask

    // Called at the first enabled cycle; lock must appear exactly LCK cycles later
    task automatic waitLock(input logic [NL-1:0] mask, input string nm);
        int at;
        at = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if ((f2a_rx_blk_lock & mask) == mask) begin
                at = k;
                break;
            end
        end
        check(nm, 128'(at), 128'(LCK));
    endtask

    // Monitor: every Rx beat must match the oldest expectation, including its due cycle
    always @(negedge pClk) begin
        exp_t e;
        if (rst_n) begin
            for (int l = 0; l < NL; l++) begin
                if (f2a_rx_valid[l]) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rx: got valid on lane %0d expected no beat", l);
                    end else begin
                        e = expQ.pop_front();
                        check("rx_lane", 128'(l), 128'(e.lane));
                        check("rx_data", f2a_rx_parallel_data[l*DW +: DW], e.data);
                        check("rx_ctrl", 128'(f2a_rx_control[l*RCW +: RCW]), 128'(e.ctrl));
                        check("rx_cycle", 128'(cycCnt), 128'(e.due));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lockAt;
        rst_n = 1'b0;
        cfg_lane_en = '0;
        a2f_tx_valid = '0;
        a2f_tx_parallel_data = '0;
        a2f_tx_control = '0;
        cfg_inject_err = 1'b0;
        cfg_err_lane = '0;
        repeat (3) tick();
        check("rst_rx_valid", 128'(f2a_rx_valid), 128'(0));
        check("rst_blk_lock", 128'(f2a_rx_blk_lock), 128'(0));
        check("rst_rx_data", 128'(|f2a_rx_parallel_data), 128'(0));
        check("rst_rx_ctrl", 128'(|f2a_rx_control), 128'(0));
        check("rst_err_armed", 128'(err_armed), 128'(0));
        check("rst_inj_cnt", 128'(inj_cnt), 128'(0));
        check("rst_drop_cnt", 128'(drop_cnt), 128'(0));

        // Bring-up with lane 1 transmitting for 10 cycles before lock
        rst_n = 1'b1;
        cfg_lane_en = 4'hF;
        a2f_tx_valid = 4'b0010;
        lockAt = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            a2f_tx_valid = (k < 10) ? 4'b0010 : 4'b0000;
            if (f2a_rx_blk_lock != 4'h0) begin
                lockAt = k;
                break;
            end
        end
        check("lock_cycle", 128'(lockAt), 128'(64));
        check("lock_all", 128'(f2a_rx_blk_lock), 128'(4'hF));
        check("drop_prelock", 128'(drop_cnt), 128'(10));

        // Directed loopback beats
        setBeat(2, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 18'h2ABCD,
                128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 20'h2ABCD, 1'b1);
        tick(); clearTx();
        setBeat(0, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 18'h00001,
                128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 20'h00001, 1'b1);
        setBeat(3, 128'h5555_5555_AAAA_AAAA_5555_5555_AAAA_AAAA, 18'h20000,
                128'h5555_5555_AAAA_AAAA_5555_5555_AAAA_AAAA, 20'h20000, 1'b1);
        tick(); clearTx();
        setBeat(1, {128{1'b1}}, 18'h3FFFF, {128{1'b1}}, 20'h3FFFF, 1'b1);
        tick(); clearTx();
        setBeat(1, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 18'h15555,
                128'h8000_0000_0000_0000_0000_0000_0000_0001, 20'h15555, 1'b1);
        tick(); clearTx();
        setBeat(1, 128'h0, 18'h0, 128'h0, 20'h0, 1'b1);
        tick(); clearTx();
        repeat (6) tick();
        check("drain1_empty", 128'(expQ.size()), 128'(0));

        // Lane 0 disabled with three beats in flight; lane 1 unaffected
        setBeat(0, 128'h1111, 18'h1, 128'h0, 20'h0, 1'b0);
        tick(); clearTx();
        setBeat(0, 128'h2222, 18'h2, 128'h0, 20'h0, 1'b0);
        tick(); clearTx();
        setBeat(0, 128'h3333, 18'h3, 128'h0, 20'h0, 1'b0);
        tick(); clearTx();
        cfg_lane_en = 4'hE;
        setBeat(1, 128'h4444_0000_0000_0000_0000_0000_0000_4444, 18'h00444,
                128'h4444_0000_0000_0000_0000_0000_0000_4444, 20'h00444, 1'b1);
        check("dis_lock_before", 128'(f2a_rx_blk_lock), 128'(4'hF));
        tick(); clearTx();
        check("dis_lock_after", 128'(f2a_rx_blk_lock), 128'(4'hE));
        repeat (8) tick();
        check("dis_empty", 128'(expQ.size()), 128'(0));
        cfg_lane_en = 4'hF;
        waitLock(4'b0001, "relock_lane0");

        // Injection targeting lane 3; a second pulse while armed is ignored
        cfg_inject_err = 1'b1;
        cfg_err_lane = 2'd3;
        tick();
        cfg_inject_err = 1'b0;
        check("inj_armed", 128'(err_armed), 128'(1));
        cfg_inject_err = 1'b1;
        cfg_err_lane = 2'd1;
        setBeat(1, 128'h00AA, 18'h0000A, 128'h00AA, 20'h0000A, 1'b1);
        tick(); clearTx();
        cfg_inject_err = 1'b0;
        check("inj_still_armed", 128'(err_armed), 128'(1));
        setBeat(1, 128'h00BB, 18'h0000B, 128'h00BB, 20'h0000B, 1'b1);
        tick(); clearTx();
        setBeat(3, 128'h0, 18'h00033, 128'h1, 20'h00033, 1'b1);
        tick(); clearTx();
        check("inj_cleared", 128'(err_armed), 128'(0));
        check("inj_cnt_1", 128'(inj_cnt), 128'(1));
        setBeat(3, 128'h0, 18'h00034, 128'h0, 20'h00034, 1'b1);
        tick(); clearTx();
        check("inj_cnt_hold", 128'(inj_cnt), 128'(1));

        // Pulse coincident with a beat on the target lane corrupts only the next beat
        cfg_inject_err = 1'b1;
        cfg_err_lane = 2'd0;
        setBeat(0, 128'hFF, 18'h000FF, 128'hFF, 20'h000FF, 1'b1);
        tick(); clearTx();
        cfg_inject_err = 1'b0;
        check("inj2_armed", 128'(err_armed), 128'(1));
        tick();
        setBeat(0, 128'hFF, 18'h000FE, 128'hFE, 20'h000FE, 1'b1);
        tick(); clearTx();
        check("inj2_cleared", 128'(err_armed), 128'(0));
        check("inj_cnt_2", 128'(inj_cnt), 128'(2));
        repeat (6) tick();
        check("drain2_empty", 128'(expQ.size()), 128'(0));

        // Drop counter saturation with all lanes down
        cfg_lane_en = 4'h0;
        tick(); tick();
        check("all_down", 128'(f2a_rx_blk_lock), 128'(0));
        check("drop_pre_sat", 128'(drop_cnt), 128'(10));
        a2f_tx_valid = 4'hF;
        repeat (16381) tick();
        check("drop_near_sat", 128'(drop_cnt), 128'(16'hFFFE));
        a2f_tx_valid = 4'b0011;
        tick();
        check("drop_sat_cross", 128'(drop_cnt), 128'(16'hFFFF));
        a2f_tx_valid = 4'hF;
        repeat (1200) tick();
        check("drop_sat_hold", 128'(drop_cnt), 128'(16'hFFFF));
        clearTx();

        // Asynchronous reset mid-stream
        cfg_lane_en = 4'hF;
        waitLock(4'hF, "relock_all");
        cfg_inject_err = 1'b1;
        cfg_err_lane = 2'd1;
        tick();
        cfg_inject_err = 1'b0;
        check("pre_rst_armed", 128'(err_armed), 128'(1));
        setBeat(2, 128'h7777, 18'h7, 128'h0, 20'h0, 1'b0);
        tick(); clearTx();
        setBeat(2, 128'h8888, 18'h8, 128'h0, 20'h0, 1'b0);
        tick(); clearTx();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(f2a_rx_valid), 128'(0));
        check("mid_rst_lock", 128'(f2a_rx_blk_lock), 128'(0));
        check("mid_rst_data", 128'(|f2a_rx_parallel_data), 128'(0));
        check("mid_rst_armed", 128'(err_armed), 128'(0));
        check("mid_rst_inj", 128'(inj_cnt), 128'(0));
        check("mid_rst_drop", 128'(drop_cnt), 128'(0));
        tick();
        rst_n = 1'b1;
        waitLock(4'hF, "post_rst_lock");
        check("post_rst_drop", 128'(drop_cnt), 128'(0));
        repeat (4) tick();
        check("final_empty", 128'(expQ.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pr_hssi_lpbk_lane_model.md
Name: pr_hssi_lpbk_lane_model

Overview:
Parametrised, cycle-accurate successor to the fixed HSSI loopback simulation model. Loops AFU Tx data/control back to AFU Rx per lane, with configurable lane count, data/control widths and pipeline latency. Adds per-lane link bring-up (block-lock) emulation, lane enable, single-bit error injection and drop/inject statistics. Sits on the FIU side of pr_hssi_if in ASE builds; it does not generate clocks.

Parameters:
NUM_LANES, 4, number of independent loopback lanes (1..16)
DATA_W, 128, parallel data bits per lane
TX_CTRL_W, 18, Tx control bits per lane
RX_CTRL_W, 20, Rx control bits per lane (>= TX_CTRL_W; upper bits zero-filled)
LATENCY, 4, Tx-to-Rx pipeline depth in cycles (>= 1)
LOCK_CYCLES, 64, cycles from lane enable to block lock (>= 1)

Ports:
pClk  in  1  single clock for all logic
rst_n  in  1  asynchronous, active-low reset
cfg_lane_en  in  NUM_LANES  per-lane enable (level)
a2f_tx_valid  in  NUM_LANES  per-lane Tx beat valid
a2f_tx_parallel_data  in  NUM_LANES*DATA_W  Tx data, lane i at [i*DATA_W +: DATA_W]
a2f_tx_control  in  NUM_LANES*TX_CTRL_W  Tx control, lane i at [i*TX_CTRL_W +: TX_CTRL_W]
cfg_inject_err  in  1  one-cycle pulse: arm a single-bit error
cfg_err_lane  in  $clog2(NUM_LANES) (min 1)  target lane for injection, sampled with pulse
f2a_rx_valid  out  NUM_LANES  per-lane Rx beat valid
f2a_rx_parallel_data  out  NUM_LANES*DATA_W  looped-back data
f2a_rx_control  out  NUM_LANES*RX_CTRL_W  {zeros, Tx control} per lane
f2a_rx_blk_lock  out  NUM_LANES  per-lane lock status
err_armed  out  1  injection armed, not yet applied
inj_cnt  out  16  injected errors, saturating
drop_cnt  out  16  Tx beats discarded because lane not locked, saturating

Behaviour:
- Reset (rst_n low, async): all outputs 0; pipelines cleared; all lanes DOWN; counters 0; err_armed 0. Applies equally mid-operation; in-flight beats are lost, not counted.
- Per-lane FSM, registered: DOWN -> LOCKING when cfg_lane_en=1 (lock counter loads 0); LOCKING increments each cycle, -> UP when counter reaches LOCK_CYCLES-1, so lock asserts exactly LOCK_CYCLES cycles after the first enabled cycle; any state -> DOWN the cycle after cfg_lane_en=0. f2a_rx_blk_lock = (state==UP).
- Ingress: a Tx beat on lane i is accepted into the pipeline iff a2f_tx_valid[i] and lane i is UP in that cycle; otherwise, if a2f_tx_valid[i]=1, it is dropped and drop_cnt increments (multiple lanes dropping in one cycle add their count; saturate at 16'hFFFF).
- Pipeline: LATENCY registered stages per lane of {valid, control, data}. Accepted beat at edge N appears on f2a_rx_* after edge N+LATENCY-1 (i.e. valid LATENCY cycles after input presented). Output valid additionally gated: f2a_rx_valid[i] = stage_valid & UP[i]; beats already in flight when a lane goes DOWN are suppressed and flushed. When valid is 0, rx data/control hold last value (no zeroing required; bench must only check under valid).
- Control width: f2a_rx_control lane i = {(RX_CTRL_W-TX_CTRL_W)'b0, tx control}.
- Error injection: cfg_inject_err pulse sets err_armed and latches cfg_err_lane (out-of-range lane value: pulse ignored). While armed, the next accepted beat on the latched lane has data bit 0 inverted at pipeline entry; err_armed clears and inj_cnt increments (saturating) on that same edge. Pulse while already armed is ignored (no re-target). Pulse in the same cycle as a qualifying beat on the target lane does not corrupt that beat; it applies to the next one. Lane going DOWN does not clear err_armed.
- No backpressure: model accepts one beat per lane per cycle indefinitely.

Test Plan:
- Reset then cfg_lane_en=4'hF, LOCK_CYCLES=64 -> f2a_rx_blk_lock=4'h0 for 63 cycles, 4'hF from cycle 64; all outputs 0 during reset.
- After lock, lane 2 sends data 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, control 18'h2ABCD -> lane 2 rx_valid exactly 4 cycles later with identical data and control 20'h2ABCD; other lanes valid=0.
- Tx valid on lane 1 before lock for 10 cycles -> drop_cnt=10, no rx_valid; 70000 drop events -> drop_cnt=16'hFFFF.
- Deassert cfg_lane_en[0] while 3 beats in flight -> no rx_valid on lane 0, lock drops next cycle; re-enable -> relock after 64 cycles.
- cfg_inject_err with cfg_err_lane=3, beat 0x...00 on lane 3 three cycles later -> rx data 0x...01, err_armed 1->0, inj_cnt=1; second pulse while armed ignored.
- Assert rst_n=0 asynchronously mid-stream -> all outputs 0 immediately, counters 0, after release lanes restart in DOWN.
